wb_arbiter: RTL
===============

# wb_arbiter

Parametrised multi-source write-back stage for the integer core. It sits between the execution units (ALU, MEM, CSR and any added units) and the register manager. It buffers each unit's results in a per-source queue and arbitrates one register write per cycle, under either a fixed-priority or a round-robin policy. Excepting results are retired without a write and reported on a dedicated exception port, and a flush input discards everything in flight.

## Interface
Parameters:
- `XLEN`, default `cpu_parameters::xlen`: data width.
- `NSRC`, default 3: number of result sources (index 0 = MEM, 1 = ALU, 2 = CSR in the default core).
- `DEPTH`, default 2: entries per source queue, ≥1.
- `RR_MODE`, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
- `SW`: derived, max(1, $clog2(NSRC)). Width of the source index.

Ports (clock and reset first):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `src_valid`  in  NSRC  result present on source i.
- `src_ready`  out  NSRC  queue i can accept a result.
- `src_data`  in  NSRC*XLEN  result data; source i occupies bits [i*XLEN +: XLEN].
- `src_rd`  in  NSRC*5  destination register; source i occupies bits [i*5 +: 5].
- `src_exc`  in  NSRC  result carries an exception.
- `flush`  in  1  discard all queued results.
- `wb_valid`  out  1  register write strobe.
- `wb_data`  out  XLEN  write data.
- `wb_adr`  out  5  write address.
- `exc_valid`  out  1  one-cycle exception report.
- `exc_src`  out  SW  source index of the reported exception.

## Operation
- Each source owns a FIFO of DEPTH entries. An entry is {data, rd, exc}. Each FIFO keeps a registered occupancy counter of width $clog2(DEPTH+1).
- `src_ready[i]` = (count_i < DEPTH). It depends only on registered state, with no combinational path from `src_valid` or the grant.
- Push: `src_valid[i] & src_ready[i]` writes the entry at the tail.
- Arbitration each cycle covers the non-empty queues, with exactly one grant when any queue is non-empty.
  - Fixed priority: the lowest index wins.
  - Round-robin: search starts at pointer `rr_ptr`. After a grant, `rr_ptr` = (winner+1) mod NSRC. The pointer holds when there is no grant.
- The granted head is always popped, whatever its type:
  - exc = 1: no register write; `exc_valid` = 1 and `exc_src` = index.
  - exc = 0, rd ≠ 0: `wb_valid` = 1 with head data and rd.
  - exc = 0, rd = 0: no write and no report; the entry is simply retired.
- Push and pop on the same queue in the same cycle leave the count unchanged; the data order is preserved.
- Flush:
  - All counts and pointers clear at the next edge.
  - Pushes in the flush cycle are dropped.
  - The grant computed in the flush cycle is suppressed: no `wb_valid` or `exc_valid` the following cycle.
  - `rr_ptr` resets to 0.

## Timing
- All outputs are registered. An entry granted in cycle t drives `wb_*` / `exc_*` in cycle t+1, held for exactly one cycle.
- Minimum latency is 1 cycle: a push accepted at edge t (queue previously empty) is granted in cycle t and appears on `wb_*` in cycle t+1.
- Reset (asynchronous assert, applicable mid-operation) clears the state:
  - Queues become empty.
  - `rr_ptr` = 0.
  - `wb_valid` = 0, `wb_data` = 0, `wb_adr` = 0.
  - `exc_valid` = 0, `exc_src` = 0.
  - `src_ready` = all ones.
- Full queue: `src_ready[i]` = 0 until the pop edge; readiness returns in the cycle after the pop.
- When `wb_valid` = 0, `wb_data`/`wb_adr` are 0. When `exc_valid` = 0, `exc_src` = 0.
- Throughput is one retirement per cycle in total, across all sources.

## Test plan
- Single ALU result: src 1 pushes data 0xDEADBEEF, rd 5 at edge 0 → `wb_valid`=1, `wb_adr`=5, `wb_data`=0xDEADBEEF in cycle 1 only; `src_ready` stays all ones.
- Fixed-priority contention (RR_MODE=0): sources 0/1/2 push rd 1/2/3 in the same cycle → writes appear in rd order 1, 2, 3 on three consecutive cycles.
- Round-robin fairness (RR_MODE=1): all three sources push continuously for 9 cycles, writes tagged by source → grant order 0,1,2,0,1,2,…; each source gets exactly 3 writes.
- Backpressure (DEPTH=2): source 0 pushes 3 back-to-back while source... (lower index absent) is blocked by forcing fixed-priority grants elsewhere; simpler form: sources 0 and 1 both push every cycle → `src_ready[1]` falls to 0 after 2 entries, no entry is lost, and FIFO order is preserved.
- Exception and rd=0: src 2 pushes exc=1, rd 7 → `exc_valid`=1, `exc_src`=2, `wb_valid`=0 next cycle. Src 1 pushes rd 0 → no write and no report, and the queue drains.
- Flush and reset mid-stream: with 4 entries queued, assert `flush` one cycle → no further `wb_valid`/`exc_valid` and `src_ready` all ones. Assert `rst_n`=0 asynchronously between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_parameters.sv
// Core-wide constants shared by the integer pipeline stages.
package cpu_parameters;
    localparam int xlen = 32;
endpackage

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source result queues feeding one register write port,
// fixed-priority or round-robin selection, exception reporting and flush.
module wb_arbiter #(
    parameter int  XLEN    = cpu_parameters::xlen,
    parameter int  NSRC    = 3,
    parameter int  DEPTH   = 2,
    parameter int  RR_MODE = 0,
    localparam int SW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [NSRC*5-1:0]    src_rd,
    input  logic [NSRC-1:0]      src_exc,
    input  logic                 flush,
    output logic                 wb_valid,
    output logic [XLEN-1:0]      wb_data,
    output logic [4:0]           wb_adr,
    output logic                 exc_valid,
    output logic [SW-1:0]        exc_src
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);
    localparam logic [SW-1:0] LAST_SRC   = SW'(NSRC - 1);

    logic [NSRC-1:0] non_empty;
    logic [XLEN-1:0] head_data [NSRC];
    logic [4:0]      head_rd   [NSRC];
    logic            head_exc  [NSRC];

    logic            grant_valid;
    logic [SW-1:0]   grant_idx;
    int              cand;
    logic [SW-1:0]   cand_idx;

    logic [SW-1:0]   rr_ptr_reg;
    logic            wb_valid_reg;
    logic [XLEN-1:0] wb_data_reg;
    logic [4:0]      wb_adr_reg;
    logic            exc_valid_reg;
    logic [SW-1:0]   exc_src_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [XLEN-1:0] data_mem [DEPTH];
            logic [4:0]      rd_mem   [DEPTH];
            logic            exc_mem  [DEPTH];
            logic [PW-1:0]   head_reg;
            logic [PW-1:0]   tail_reg;
            logic [CW-1:0]   count_reg;
            logic            push;
            logic            pop;

            // Readiness comes from the registered count only, so a pop does not free a slot until the next cycle.
            assign src_ready[gi] = (count_reg < FULL_COUNT);
            assign non_empty[gi] = (count_reg != '0);
            assign push = src_valid[gi] & src_ready[gi] & ~flush;
            assign pop  = grant_valid & (grant_idx == SW'(gi)) & ~flush;

            always_ff @(posedge clk) begin
                if (push) begin
                    data_mem[tail_reg] <= src_data[gi*XLEN +: XLEN];
                    rd_mem[tail_reg]   <= src_rd[gi*5 +: 5];
                    exc_mem[tail_reg]  <= src_exc[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else if (flush) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (push) begin
                        tail_reg <= (tail_reg == LAST_SLOT) ? '0 : tail_reg + 1'b1;
                    end
                    if (pop) begin
                        head_reg <= (head_reg == LAST_SLOT) ? '0 : head_reg + 1'b1;
                    end
                    if (push && !pop) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (pop && !push) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end

            assign head_data[gi] = data_mem[head_reg];
            assign head_rd[gi]   = rd_mem[head_reg];
            assign head_exc[gi]  = exc_mem[head_reg];
        end
    endgenerate

    // Search from index 0 in fixed mode, or from rr_ptr (wrapping) in round-robin mode.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NSRC; k++) begin
            cand = (RR_MODE != 0) ? int'(rr_ptr_reg) + k : k;
            if (cand >= NSRC) begin
                cand = cand - NSRC;
            end
            cand_idx = cand[SW-1:0];
            if (!grant_valid && non_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            wb_valid_reg  <= 1'b0;
            wb_data_reg   <= '0;
            wb_adr_reg    <= '0;
            exc_valid_reg <= 1'b0;
            exc_src_reg   <= '0;
        end else begin
            wb_valid_reg  <= 1'b0;
            wb_data_reg   <= '0;
            wb_adr_reg    <= '0;
            exc_valid_reg <= 1'b0;
            exc_src_reg   <= '0;
            if (flush) begin
                rr_ptr_reg <= '0;
            end else if (grant_valid) begin
                rr_ptr_reg <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
                // Writes to x0 are retired silently: neither a write nor a report.
                if (head_exc[grant_idx]) begin
                    exc_valid_reg <= 1'b1;
                    exc_src_reg   <= grant_idx;
                end else if (head_rd[grant_idx] != 5'd0) begin
                    wb_valid_reg <= 1'b1;
                    wb_data_reg  <= head_data[grant_idx];
                    wb_adr_reg   <= head_rd[grant_idx];
                end
            end
        end
    end

    assign wb_valid  = wb_valid_reg;
    assign wb_data   = wb_data_reg;
    assign wb_adr    = wb_adr_reg;
    assign exc_valid = exc_valid_reg;
    assign exc_src   = exc_src_reg;

endmodule
